// File: rtl/core_pkg.sv
// Shared core types for the register-file writeback path.
package core_pkg;

  localparam int unsigned XLEN_C     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_C-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous circular FIFO of writeback entries; head is readable combinationally.
module wb_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  wb_entry_t                  i_push_data,
  input  logic                       i_pop,
  output wb_entry_t                  o_head_c,
  output logic                       o_full_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pushes into a full FIFO and pops from an empty one are dropped.
  always_comb begin
    o_full_c  = (r_count == CNT_W'(DEPTH));
    o_empty_c = (r_count == '0);
    w_do_push = i_push && !o_full_c;
    w_do_pop  = i_pop && !o_empty_c;
    o_head_c  = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU results and buffered load returns onto the single regfile write port,
// and tracks outstanding loads per destination register for decode hazard stalls.
module rf_writeback_arbiter
  import core_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_C,
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [4:0]                  alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  output logic                        alu_ready,
  input  logic                        ld_issue,
  input  logic [4:0]                  ld_issue_rd,
  input  logic                        mem_valid,
  input  logic [4:0]                  mem_rd,
  input  logic [XLEN-1:0]             mem_data,
  output logic                        mem_ready,
  output logic                        rf_write,
  output logic [4:0]                  rf_write_reg,
  output logic [XLEN-1:0]             rf_write_data,
  output logic [31:0]                 busy,
  output logic [$clog2(LQ_DEPTH):0]   lq_count
);

  localparam int unsigned CNT_W = $clog2(LQ_DEPTH) + 1;

  wb_entry_t             w_push_entry;
  wb_entry_t             w_head;
  logic                  w_lq_full;
  logic                  w_lq_empty;
  logic [CNT_W-1:0]      w_lq_count;
  logic                  w_push;
  logic                  w_alu_take;
  logic                  w_fifo_pop;
  logic                  w_sel_valid;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic [NUM_REGS-1:0]   w_busy_nxt;

  logic                  r_rf_write;
  logic [REG_ADDR_W-1:0] r_rf_write_reg;
  logic [XLEN-1:0]       r_rf_write_data;
  logic [NUM_REGS-1:0]   r_busy;

  wb_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_fifo_pop),
    .o_head_c    (w_head),
    .o_full_c    (w_lq_full),
    .o_empty_c   (w_lq_empty),
    .o_count     (w_lq_count)
  );

  // Source select: ALU first, except a full load queue forces the head out to avoid starvation.
  always_comb begin
    w_push_entry      = '0;
    w_push            = 1'b0;
    w_alu_take        = 1'b0;
    w_fifo_pop        = 1'b0;
    w_sel_valid       = 1'b0;
    w_sel_rd          = '0;
    w_sel_data        = '0;

    w_push_entry.rd   = mem_rd;
    w_push_entry.data = XLEN_C'(mem_data);
    w_push            = mem_valid && !w_lq_full;

    if (w_lq_full) begin
      w_fifo_pop = 1'b1;
    end else if (alu_valid) begin
      w_alu_take = 1'b1;
    end else if (!w_lq_empty) begin
      w_fifo_pop = 1'b1;
    end

    if (w_alu_take) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = alu_rd;
      w_sel_data  = alu_data;
    end else if (w_fifo_pop) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = w_head.rd;
      w_sel_data  = XLEN'(w_head.data);
    end
  end

  // Pending-load scoreboard: a new issue overrides a same-cycle retire of that register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_fifo_pop) w_busy_nxt[w_head.rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0)) w_busy_nxt[ld_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_write      <= 1'b0;
      r_rf_write_reg  <= '0;
      r_rf_write_data <= '0;
      r_busy          <= '0;
    end else begin
      r_rf_write <= w_sel_valid && (w_sel_rd != '0);
      if (w_sel_valid) begin
        r_rf_write_reg  <= w_sel_rd;
        r_rf_write_data <= w_sel_data;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign alu_ready     = !w_lq_full;
  assign mem_ready     = !w_lq_full;
  assign rf_write      = r_rf_write;
  assign rf_write_reg  = r_rf_write_reg;
  assign rf_write_data = r_rf_write_data;
  assign busy          = r_busy;
  assign lq_count      = w_lq_count;

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
Producer side of the register-file write port. It merges ALU results (single-cycle) and load returns (variable latency) into the single port signals `write`, `writeReg` and `writeData`. Load returns are buffered in a small FIFO. A pending-load scoreboard lets decode stall on RAW hazards. One instance sits per core, between the execute/LSU stage and the register file.

Parameters:
XLEN, 32, data width of the write port
LQ_DEPTH, 4, load-return FIFO depth (power of two, >=2)

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU result present this cycle
alu_rd  input  5  ALU destination register
alu_data  input  XLEN  ALU result
alu_ready  output  1  ALU result accepted this cycle (combinational)
ld_issue  input  1  load issued to LSU this cycle
ld_issue_rd  input  5  destination of the issued load
mem_valid  input  1  load data returning
mem_rd  input  5  destination of the returning load
mem_data  input  XLEN  returned load data
mem_ready  output  1  FIFO can accept a return (= !lq_full)
rf_write  output  1  drives regfile `write`
rf_write_reg  output  5  drives regfile `writeReg`
rf_write_data  output  XLEN  drives regfile `writeData`
busy  output  32  scoreboard; bit n set = load to xn outstanding
lq_count  output  $clog2(LQ_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async on rst_n low): rf_write=0, rf_write_reg=0, rf_write_data=0, busy=0, FIFO empty, lq_count=0. Reset mid-operation discards buffered loads.
- A load return is accepted on mem_valid && mem_ready. Accepted entries {rd,data} are pushed at the clock edge; no bypass, so an entry is visible at the head the next cycle.
- The arbiter picks one source per cycle:
  - Default priority: ALU > FIFO head.
  - Anti-starvation: when lq_full, the FIFO head wins and alu_ready=0.
  - alu_ready = !lq_full.
- Write port registered (1-cycle latency). The selected {rd,data} appear on rf_write_* the cycle after selection.
  - rf_write=1 only if the selected rd != 0.
  - rd=0 selections are consumed (FIFO popped / ALU accepted) but drive rf_write=0.
  - When nothing is selected: rf_write=0; rf_write_reg and rf_write_data hold their last values.
- FIFO:
  - Circular buffer with wrapping read/write pointers and an occupancy counter.
  - Simultaneous push and pop while full: push is blocked because mem_ready=0.
  - Simultaneous push and pop while empty: the pop is impossible (head invalid); the push proceeds.
- Scoreboard:
  - ld_issue with ld_issue_rd != 0 sets busy[rd] at the edge.
  - A FIFO pop of rd clears busy[rd] at the same edge the write is registered.
  - Same-cycle set and clear of the same rd: set wins.
  - busy[0] is always 0.
- Protocol rules (assertions in the bench, not checked in RTL):
  - No ld_issue to an rd already busy.
  - Load returns arrive in issue order.
  - mem_valid is never asserted for an rd that is not busy.
- Downstream regfile: its same-cycle forwarding makes data written at edge N readable by a read issued in cycle N. Decode uses busy (registered) plus that forwarding, so no extra bypass is needed here.

Decomposition:
- Shared package core_pkg:
  - XLEN_C
  - REG_ADDR_W = 5
  - typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;}
- One natural sub-module: wb_fifo (parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count). The arbiter, output register and scoreboard live in rf_writeback_arbiter.

Test Plan:
1. Reset, then alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle → next cycle rf_write=1, reg=5, data=0xDEADBEEF; following cycle rf_write=0.
2. Issue load to x7; two cycles later mem_valid with rd=7, data=0x1234 while ALU idle → busy[7]=1 until the write cycle; rf_write on x7 two cycles after mem_valid; busy[7]=0 that cycle.
3. Same cycle ALU (rd=3, 0xA) and mem return (rd=4, 0xB) → x3 written first, x4 the following cycle; lq_count goes 0→1→0.
4. Continuous alu_valid while 4 loads return back-to-back → lq_count reaches 4, mem_ready=0 and alu_ready=0. The head drains, the ALU resumes once count=3, and all 4 loads are written in order.
5. ALU rd=0, data=0xFFFF and load to x0 → no rf_write asserted, FIFO drains, busy stays 0.
6. Fill FIFO with 3 entries, pulse rst_n low asynchronously mid-cycle → all outputs zero immediately; after release, no stale writes appear.
